// File: rtl/uart_rx_async_if.sv
// Host-side handshake of the UART receiver: received character, status flags,
// the read strobe that acknowledges a character, and the FIFO write strobe.
interface uart_rx_async_if;
  logic       read_rx_byte;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       overflow;
  logic       parity_err;
  logic       framing_err;
  logic       fifo_write_n;

  // Host / FIFO side: issues reads, observes data and status.
  modport master (
    output read_rx_byte,
    input  rx_data, rx_ready, overflow, parity_err, framing_err, fifo_write_n
  );

  // Receiver side: accepts reads, presents data and status.
  modport slave (
    input  read_rx_byte,
    output rx_data, rx_ready, overflow, parity_err, framing_err, fifo_write_n
  );
endinterface

// File: rtl/uart_rx_async.sv
// Asynchronous UART receiver with 16x oversampling. Recovers 7/8-bit characters
// with optional odd/even parity and hands them to a holding register (ready /
// overflow handshake) and, optionally, to the RX FIFO via an active-low strobe.
module uart_rx_async #(
  parameter bit RX_FIFO = 1'b0
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        baud_pulse,
  input  logic        rx,
  input  logic        bit8,
  input  logic        parity_en,
  input  logic        odd_n_even,
  uart_rx_async_if.slave host
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state, state_nxt;
  logic       rx_meta, rx_s;
  logic [3:0] samp_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       par_bad;
  logic       samp_clr, bit_clr, shift_en, par_ld, load;
  logic       last_bit;
  logic [7:0] rx_char;

  logic [7:0] rx_data_q;
  logic       rx_ready_q, overflow_q, parity_err_q, framing_err_q, fifo_write_n_q;

  // Bits arrive LSB first into the MSB, so a 7-bit character sits in [7:1]
  // and must be shifted down one place with bit 7 forced to 0.
  function automatic logic [7:0] align_char(input logic [7:0] sr, input logic b8);
    return b8 ? sr : {1'b0, sr[7:1]};
  endfunction

  assign rx_char  = align_char(shreg, bit8);
  // The >= form lets DATA exit even if bit8 drops while bit_cnt is already 7.
  assign last_bit = bit8 ? (bit_cnt == 3'd7) : (bit_cnt >= 3'd6);

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and datapath strobes; every transition waits for a baud pulse.
  always_comb begin
    state_nxt = state;
    samp_clr  = 1'b0;
    bit_clr   = 1'b0;
    shift_en  = 1'b0;
    par_ld    = 1'b0;
    load      = 1'b0;
    if (baud_pulse) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt = START;
            samp_clr  = 1'b1;
          end
        end
        START: begin
          if (samp_cnt == 4'd7) begin
            if (rx_s) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = DATA;
              samp_clr  = 1'b1;
              bit_clr   = 1'b1;
            end
          end
        end
        DATA: begin
          if (samp_cnt == 4'd15) begin
            shift_en = 1'b1;
            if (last_bit) state_nxt = parity_en ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (samp_cnt == 4'd15) begin
            par_ld    = 1'b1;
            state_nxt = STOP;
          end
        end
        STOP: begin
          // Load at mid stop bit so a following start edge is not missed.
          if (samp_cnt == 4'd15) begin
            load      = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Oversample and bit counters, shift register and parity capture.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      samp_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'd0;
      par_bad  <= 1'b0;
    end else begin
      if (samp_clr)        samp_cnt <= 4'd0;
      else if (baud_pulse) samp_cnt <= samp_cnt + 4'd1;

      if (bit_clr) begin
        bit_cnt <= 3'd0;
        shreg   <= 8'd0;
        par_bad <= 1'b0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
        shreg   <= {rx_s, shreg[7:1]};
      end

      if (par_ld) par_bad <= rx_s ^ odd_n_even ^ (^rx_char);
    end
  end

  // Host-visible holding register and status; a load beats a coincident read.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rx_data_q      <= 8'd0;
      rx_ready_q     <= 1'b0;
      overflow_q     <= 1'b0;
      parity_err_q   <= 1'b0;
      framing_err_q  <= 1'b0;
      fifo_write_n_q <= 1'b1;
    end else begin
      fifo_write_n_q <= ~(load & RX_FIFO);
      if (load) begin
        rx_data_q     <= rx_char;
        framing_err_q <= ~rx_s;
        parity_err_q  <= par_bad & parity_en;
        rx_ready_q    <= 1'b1;
        overflow_q    <= (rx_ready_q | overflow_q) & ~host.read_rx_byte;
      end else if (host.read_rx_byte) begin
        rx_ready_q <= 1'b0;
        overflow_q <= 1'b0;
      end
    end
  end

  assign host.rx_data      = rx_data_q;
  assign host.rx_ready     = rx_ready_q;
  assign host.overflow     = overflow_q;
  assign host.parity_err   = parity_err_q;
  assign host.framing_err  = framing_err_q;
  assign host.fifo_write_n = fifo_write_n_q;

endmodule
